// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit layout and the transmitter FSM state encoding.
package uart_pkg;

   localparam logic [31:0] UART_TXDATA_OFS = 32'h0;
   localparam logic [31:0] UART_STATUS_OFS = 32'h4;

   localparam int STAT_BUSY_BIT  = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_EMPTY_BIT = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_CNT_LSB   = 4;
   localparam int STAT_CNT_W     = 4;

   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_START_ENC  = 3'd1;
   localparam logic [2:0] ST_DATA_ENC   = 3'd2;
   localparam logic [2:0] ST_PARITY_ENC = 3'd3;
   localparam logic [2:0] ST_STOP_ENC   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_START  = ST_START_ENC,
      ST_DATA   = ST_DATA_ENC,
      ST_PARITY = ST_PARITY_ENC,
      ST_STOP   = ST_STOP_ENC
   } uart_state_e;

   function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [STAT_CNT_W-1:0] cnt);
      logic [31:0] s;
      s = '0;
      s[STAT_BUSY_BIT]  = busy;
      s[STAT_FULL_BIT]  = full;
      s[STAT_EMPTY_BIT] = empty;
      s[STAT_OVF_BIT]   = ovf;
      s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, first-word fall-through, active-low synchronous reset.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS window, TX FIFO, 8-N-1 serialiser.
// Define UART_PARITY_EN to insert an even-parity bit (8-E-1 frames).
//
// state   | meaning
// IDLE    | line high, waiting for a byte in the FIFO
// START   | start bit, tx low for CLK_DIV cycles
// DATA    | 8 data bits LSB first, CLK_DIV cycles each
// PARITY  | even parity bit (only with UART_PARITY_EN)
// STOP    | stop bit, tx high; chains straight into START if more data
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter int          CLK_DIV    = 868,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        sel,
   output logic        tx
);
   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

   logic          hit_data, hit_stat;
   logic          push, ovf_set, ovf_clr;
   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          baud_end;
   logic          tx_c;
   logic          unused_wd;

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          ovf_q, ovf_d;
`ifdef UART_PARITY_EN
   logic          par_q, par_d;
`endif

   assign hit_data  = (addr == BASE_ADDR + UART_TXDATA_OFS);
   assign hit_stat  = (addr == BASE_ADDR + UART_STATUS_OFS);
   assign sel       = hit_data | hit_stat;
   assign push      = we & hit_data & ~fifo_full;
   assign ovf_set   = we & hit_data & fifo_full;
   assign ovf_clr   = we & hit_stat & wd[STAT_OVF_BIT];
   assign unused_wd = ^wd[31:8];

   assign rd = hit_stat ? pack_status(state_q != ST_IDLE, fifo_full, fifo_empty, ovf_q,
                                      STAT_CNT_W'(fifo_count))
                        : 32'h0;
   assign tx = tx_c;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (fifo_pop),
      .din   (wd[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A dropped push wins over a simultaneous clear so no loss goes unreported.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_set)      ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   assign baud_end = (baud_q == BAUD_MAX);

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      tx_c     = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            tx_c = 1'b0;
            if (baud_end) begin
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            tx_c = shift_q[0];
            if (baud_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx_c = par_q;
            if (baud_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (baud_end) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = ST_START;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q || baud_end || state_q == ST_IDLE) baud_d = '0;
      else                                                      baud_d = baud_q + BW'(1);
   end

`ifdef UART_PARITY_EN
   // Parity is captured at load time because the shift register is consumed by the time it is sent.
   always_comb begin
      par_d = par_q;
      if (fifo_pop) par_d = ^fifo_dout;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         ovf_q   <= 1'b0;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ovf_q   <= ovf_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule
